sc_io_ports: RTL and testbench

Parametrised memory-mapped I/O unit for the single-cycle CPU. It generalises the fixed two-input/three-output port set to N_IN synchronised input channels and N_OUT output registers. It adds per-channel change detection, an interrupt mask with an irq output, and a free-running cycle counter. It sits beside the data memory; the top level muxes its rdata against memory output using io_sel.

---
 rtl/sc_io_pkg.sv | 9 +
 rtl/sc_io_sync_detect.sv | 27 ++
 rtl/sc_io_ports.sv | 85 ++++++++
 tb/tb_sc_io_ports.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/sc_io_pkg.sv
// sc_io_pkg: register offsets and defaults for the memory-mapped I/O unit
package sc_io_pkg;
  localparam logic [4:0] OFF_OUT_BASE = 5'd0;
  localparam logic [4:0] OFF_IN_BASE  = 5'd16;
  localparam logic [4:0] OFF_MASK     = 5'd29;
  localparam logic [4:0] OFF_STATUS   = 5'd30;
  localparam logic [4:0] OFF_CYCLE    = 5'd31;
  localparam int IO_SEL_BIT_DEF = 7;
endpackage

// File: rtl/sc_io_sync_detect.sv
// sc_io_sync_detect: 3-stage input synchroniser; sync_o = stage 2, change_o = stage 2 differs from stage 3
module sc_io_sync_detect
  import sc_io_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_i,
  output logic [WIDTH-1:0] sync_o,
  output logic             change_o
);
  logic [WIDTH-1:0] s1_q, s2_q, s3_q;
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      s1_q <= in_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end
  assign sync_o   = s2_q;
  assign change_o = s2_q != s3_q;
endmodule

// File: rtl/sc_io_ports.sv
// sc_io_ports: memory-mapped OUT/IN/MASK/STATUS/CYCLE registers with change-detect irq for the single-cycle CPU
module sc_io_ports
  import sc_io_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int ADDR_W     = 32,
  parameter int N_IN       = 2,
  parameter int N_OUT      = 3,
  parameter int IO_SEL_BIT = IO_SEL_BIT_DEF
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [ADDR_W-1:0]      addr,
  input  logic                   we,
  input  logic                   re,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   io_sel,
  input  logic [N_IN*WIDTH-1:0]  in_ports,
  output logic [N_OUT*WIDTH-1:0] out_ports,
  output logic                   irq
);
  logic [4:0] off;
  logic wr, clr;
  logic [WIDTH-1:0] in_s [N_IN];
  logic [N_IN-1:0] chg;
  logic [WIDTH-1:0] out_q [N_OUT];
  logic [WIDTH-1:0] out_d [N_OUT];
  logic [N_IN-1:0] mask_q, mask_d, status_q, status_d;
  logic [WIDTH-1:0] cycle_q;
  logic irq_q;
  logic unused_bits;
  assign off    = addr[6:2];
  assign io_sel = addr[IO_SEL_BIT];
  assign wr     = we & io_sel;
  assign clr    = re & io_sel & (off == OFF_STATUS);
  assign irq    = irq_q;
  assign unused_bits = ^{addr, wdata};
  for (genvar i = 0; i < N_IN; i++) begin : g_in
    sc_io_sync_detect #(.WIDTH(WIDTH)) u_sync (
      .clock   (clock),
      .reset   (reset),
      .in_i    (in_ports[i*WIDTH +: WIDTH]),
      .sync_o  (in_s[i]),
      .change_o(chg[i])
    );
  end
  for (genvar k = 0; k < N_OUT; k++) begin : g_out
    assign out_ports[k*WIDTH +: WIDTH] = out_q[k];
  end
  // A change event arriving on the clearing edge re-sets its flag.
  always_comb begin
    for (int k = 0; k < N_OUT; k++)
      out_d[k] = (wr && off == OFF_OUT_BASE + 5'(k)) ? wdata : out_q[k];
    mask_d   = (wr && off == OFF_MASK) ? wdata[N_IN-1:0] : mask_q;
    status_d = (clr ? '0 : status_q) | chg;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < N_OUT; k++) out_q[k] <= '0;
      mask_q   <= '0;
      status_q <= '0;
      cycle_q  <= '0;
      irq_q    <= 1'b0;
    end else begin
      for (int k = 0; k < N_OUT; k++) out_q[k] <= out_d[k];
      mask_q   <= mask_d;
      status_q <= status_d;
      cycle_q  <= cycle_q + 1'b1;
      irq_q    <= |(status_d & mask_d);
    end
  end
  always_comb begin
    rdata = '0;
    if (io_sel) begin
      for (int k = 0; k < N_OUT; k++)
        if (off == OFF_OUT_BASE + 5'(k)) rdata = out_q[k];
      for (int i = 0; i < N_IN; i++)
        if (off == OFF_IN_BASE + 5'(i)) rdata = in_s[i];
      if (off == OFF_MASK) rdata = WIDTH'(mask_q);
      if (off == OFF_STATUS) rdata = WIDTH'(status_q);
      if (off == OFF_CYCLE) rdata = cycle_q;
    end
  end
endmodule

// File: tb/tb_sc_io_ports.sv
// tb_sc_io_ports: directed plus random checks of sc_io_ports against a behavioural model
module tb_sc_io_ports;
  logic clk = 1'b0;
  logic reset;
  logic [31:0] addr, wdata, rdata;
  logic we, re, io_sel, irq;
  logic [63:0] in_ports;
  logic [95:0] out_ports;
  logic [7:0] rdata8;
  logic io_sel8, irq8;
  logic [23:0] out8;
  int checks = 0, errors = 0;
  bit live = 0;
  logic [31:0] m_out [3];
  logic [1:0] m_mask, m_status;
  logic [31:0] m_cycle;
  logic m_irq;
  logic [63:0] h [3];
  logic [4:0] offs [12] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd10, 5'd16, 5'd17, 5'd18, 5'd29, 5'd30, 5'd31, 5'd31};
  always #5 clk = ~clk;
  sc_io_ports dut (
    .clock(clk), .reset(reset), .addr(addr), .we(we), .re(re), .wdata(wdata),
    .rdata(rdata), .io_sel(io_sel), .in_ports(in_ports), .out_ports(out_ports), .irq(irq)
  );
  sc_io_ports #(.WIDTH(8)) u8 (
    .clock(clk), .reset(reset), .addr(addr), .we(we), .re(re), .wdata(wdata[7:0]),
    .rdata(rdata8), .io_sel(io_sel8), .in_ports({in_ports[39:32], in_ports[7:0]}),
    .out_ports(out8), .irq(irq8)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] exp_rd(input logic [31:0] a);
    logic [4:0] o;
    o = a[6:2];
    if (!a[7]) return 32'h0;
    if (o < 5'd3) return m_out[o[1:0]];
    if (o == 5'd16) return h[1][31:0];
    if (o == 5'd17) return h[1][63:32];
    if (o == 5'd29) return {30'h0, m_mask};
    if (o == 5'd30) return {30'h0, m_status};
    if (o == 5'd31) return m_cycle;
    return 32'h0;
  endfunction
  // Inputs become readable two edges after they are sampled; a flag rises
  // one edge after a readable value differs from the one before it.
  task automatic model_edge();
    logic [1:0] ev;
    logic [4:0] o;
    if (reset) begin
      foreach (m_out[k]) m_out[k] = '0;
      foreach (h[k]) h[k] = '0;
      m_mask = 0; m_status = 0; m_cycle = 0; m_irq = 0;
    end else begin
      ev = {h[1][63:32] != h[2][63:32], h[1][31:0] != h[2][31:0]};
      o = addr[6:2];
      if (addr[7] && re && o == 5'd30) m_status = 0;
      m_status |= ev;
      if (addr[7] && we) begin
        if (o < 5'd3) m_out[o[1:0]] = wdata;
        if (o == 5'd29) m_mask = wdata[1:0];
      end
      m_cycle++;
      m_irq = |(m_status & m_mask);
      h[2] = h[1]; h[1] = h[0]; h[0] = in_ports;
    end
  endtask
  task automatic tick();
    #1;
    if (live) begin
      chk("rdata", rdata, exp_rd(addr));
      chk("io_sel", 32'(io_sel), 32'(addr[7]));
      if (addr[7] && addr[6:2] == 5'd31) chk("cycle8", 32'(rdata8), 32'(m_cycle[7:0]));
    end
    @(posedge clk);
    model_edge();
    if (reset) live = 1;
    #1;
    if (live) begin
      for (int k = 0; k < 3; k++) chk("out_ports", out_ports[k*32 +: 32], m_out[k]);
      chk("irq", 32'(irq), 32'(m_irq));
    end
  endtask
  task automatic peek(input string tag, input logic [31:0] exp);
    #1;
    chk(tag, rdata, exp);
  endtask
  initial begin
    reset = 1; addr = 0; we = 0; re = 0; wdata = 0; in_ports = 0;
    tick(); tick();
    reset = 0;
    addr = 32'h80; peek("rst_out0", 0);
    addr = 32'hF4; peek("rst_mask", 0);
    addr = 32'hF8; peek("rst_status", 0);
    addr = 32'hFC; peek("rst_cycle", 0);
    tick();
    addr = 32'h84; we = 1; wdata = 32'hDEADBEEF; tick(); we = 0;
    chk("out1_write", out_ports[63:32], 32'hDEADBEEF);
    addr = 32'h04; we = 1; wdata = 32'h12345678; tick(); we = 0;
    chk("out1_nosel", out_ports[63:32], 32'hDEADBEEF);
    addr = 32'hA8; we = 1; wdata = 32'hFFFFFFFF; tick(); we = 0;
    peek("off10", 0);
    addr = 32'hF4; we = 1; wdata = 32'h1; tick(); we = 0;
    in_ports[31:0] = 32'h5A; addr = 32'hC0;
    tick(); peek("in0_1edge", 0);
    tick(); peek("in0_2edge", 32'h5A);
    chk("irq_2edge", 32'(irq), 0);
    tick(); chk("irq_set", 32'(irq), 1);
    addr = 32'hF8; peek("status_set", 1);
    re = 1; tick(); re = 0;
    chk("irq_clr", 32'(irq), 0);
    peek("status_clr", 0);
    in_ports[63:32] = 32'h33;
    tick(); tick();
    re = 1; tick(); re = 0;
    peek("status_set_wins", 2);
    chk("irq_masked", 32'(irq), 0);
    addr = 32'hF4; we = 1; wdata = 32'h3; tick(); we = 0;
    chk("irq_unmask", 32'(irq), 1);
    addr = 32'hF8; re = 1; tick(); re = 0;
    addr = 32'h80; we = 1; wdata = 32'hAAAA5555; reset = 1; tick(); reset = 0; we = 0;
    chk("rst_mid_out0", out_ports[31:0], 0);
    chk("rst_mid_irq", 32'(irq), 0);
    addr = 32'hFC; peek("rst_mid_cycle", 0);
    for (int n = 0; n < 300 && m_cycle != 32'd255; n++) tick();
    #1; chk("wrap_ff", 32'(rdata8), 32'hFF);
    tick();
    #1; chk("wrap_00", 32'(rdata8), 32'h00);
    chk("cycle32_256", rdata, 32'd256);
    for (int n = 0; n < 600; n++) begin
      addr = $urandom();
      addr[7] = $urandom_range(0, 7) != 0;
      addr[6:2] = offs[$urandom_range(0, 11)];
      we = $urandom_range(0, 2) == 0;
      re = $urandom_range(0, 2) == 0;
      wdata = $urandom();
      if ($urandom_range(0, 3) == 0) in_ports[$urandom_range(0, 1)*32 +: 32] = 32'($urandom_range(0, 3));
      reset = $urandom_range(0, 99) == 0;
      tick();
    end
    reset = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
